// File: rtl/serial_subtractor_pkg.sv
// Shared definitions for the bit-serial subtractor.
//   DEFAULT_WIDTH : default operand/result width
//   state_t       : handshake FSM encoding (IDLE=0, RUN=1, DONE=2)
package serial_subtractor_pkg;

  localparam int DEFAULT_WIDTH = 8;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

endpackage

// File: rtl/serial_subtractor_full_subtractor.sv
// 1-bit full subtractor cell: computes x - y - bin.
//   x, y : operand bits
//   bin  : borrow in
//   d    : difference bit
//   bout : borrow out
module full_subtractor (
  input  logic x,
  input  logic y,
  input  logic bin,
  output logic d,
  output logic bout
);

  assign d    = x ^ y ^ bin;
  assign bout = (~x & y) | (~(x ^ y) & bin);

endmodule

// File: rtl/serial_subtractor.sv
// Bit-serial unsigned subtractor: diff = a - b mod 2^WIDTH, LSB first,
// one bit per clock through a single full_subtractor cell.
//   clk, rst   : clock, synchronous active-high reset
//   start      : request, accepted in IDLE or DONE
//   a, b       : minuend / subtrahend, captured on the accepting edge
//   busy       : high while bits are being processed
//   done       : one-cycle pulse when diff/borrow_out are fresh
//   diff       : result, held until the next operation completes
//   borrow_out : 1 iff a < b (unsigned), held with diff
module serial_subtractor
  import serial_subtractor_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] diff,
  output logic             borrow_out
);

  localparam int CW = $clog2(WIDTH) + 1;

  state_t           state, state_next;
  logic [CW-1:0]    cnt;
  logic [WIDTH-1:0] a_sr, b_sr, res_sr;
  logic             bin, d, bout;
  logic             last, accept;

  full_subtractor u_cell (
    .x    (a_sr[0]),
    .y    (b_sr[0]),
    .bin  (bin),
    .d    (d),
    .bout (bout)
  );

  assign last   = (cnt == CW'(WIDTH - 1));
  // DONE accepts like IDLE so operations can run back-to-back.
  assign accept = start && (state != RUN);

  always_comb begin
    state_next = state;
    busy       = 1'b0;
    done       = 1'b0;
    case (state)
      IDLE: if (start) state_next = RUN;
      RUN: begin
        busy = 1'b1;
        if (last) state_next = DONE;
      end
      DONE: begin
        done       = 1'b1;
        state_next = start ? RUN : IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_next;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt        <= '0;
      a_sr       <= '0;
      b_sr       <= '0;
      res_sr     <= '0;
      bin        <= 1'b0;
      diff       <= '0;
      borrow_out <= 1'b0;
    end else if (accept) begin
      a_sr <= a;
      b_sr <= b;
      bin  <= 1'b0;
      cnt  <= '0;
    end else if (state == RUN) begin
      a_sr   <= a_sr >> 1;
      b_sr   <= b_sr >> 1;
      res_sr <= {d, res_sr[WIDTH-1:1]};
      bin    <= bout;
      cnt    <= cnt + CW'(1);
      // Visible outputs change only on the final bit so a held result
      // stays stable for the whole of the next operation.
      if (last) begin
        diff       <= {d, res_sr[WIDTH-1:1]};
        borrow_out <= bout;
      end
    end
  end

endmodule

// File: tb/tb_serial_subtractor.sv
module tb_serial_subtractor;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic        start8 = 1'b0;
  logic [7:0]  a8 = '0, b8 = '0, diff8;
  logic        busy8, done8, bo8;
  logic        start16 = 1'b0;
  logic [15:0] a16 = '0, b16 = '0, diff16;
  logic        busy16, done16, bo16;
  logic        cx = 1'b0, cy = 1'b0, cb = 1'b0, cd, cbo;

  int checks = 0;
  int failures = 0;

  serial_subtractor #(.WIDTH(8)) dut8 (
    .clk(clk), .rst(rst), .start(start8), .a(a8), .b(b8),
    .busy(busy8), .done(done8), .diff(diff8), .borrow_out(bo8)
  );

  serial_subtractor #(.WIDTH(16)) dut16 (
    .clk(clk), .rst(rst), .start(start16), .a(a16), .b(b16),
    .busy(busy16), .done(done16), .diff(diff16), .borrow_out(bo16)
  );

  full_subtractor u_fs (.x(cx), .y(cy), .bin(cb), .d(cd), .bout(cbo));

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  typedef struct {
    logic [7:0] a;
    logic [7:0] b;
    logic [7:0] d;
    logic       bo;
  } vec_t;
  vec_t vt[9];
  logic [1:0] fs_exp[8];

  task automatic drive(input int w, input logic s, input logic [31:0] av, input logic [31:0] bv);
    if (w == 8) begin start8 = s; a8 = av[7:0]; b8 = bv[7:0]; end
    else begin start16 = s; a16 = av[15:0]; b16 = bv[15:0]; end
  endtask

  function automatic logic [31:0] o_diff(input int w);
    return (w == 8) ? {24'd0, diff8} : {16'd0, diff16};
  endfunction
  function automatic logic o_busy(input int w);
    return (w == 8) ? busy8 : busy16;
  endfunction
  function automatic logic o_done(input int w);
    return (w == 8) ? done8 : done16;
  endfunction
  function automatic logic o_bo(input int w);
    return (w == 8) ? bo8 : bo16;
  endfunction

  // One start pulse, then wait (bounded) for done and check result/timing.
  task automatic run_op(input int w, input logic [31:0] av, input logic [31:0] bv,
                        input logic [31:0] ed, input logic eb, input string tag);
    int n = 0;
    int busy_n = 0;
    bit got = 0;
    @(negedge clk);
    drive(w, 1'b1, av, bv);
    while (n < w + 4 && !got) begin
      @(negedge clk);
      n++;
      if (n == 1) drive(w, 1'b0, av, bv);
      if (o_busy(w)) busy_n++;
      if (o_done(w)) got = 1;
    end
    chk({tag, " done_seen"}, 32'(got), 32'd1);
    if (got) begin
      chk({tag, " latency"}, 32'(n), 32'(w + 1));
      chk({tag, " busy_cycles"}, 32'(busy_n), 32'(w));
      chk({tag, " diff"}, o_diff(w), ed);
      chk({tag, " borrow"}, 32'(o_bo(w)), 32'(eb));
      @(negedge clk);
      chk({tag, " done_one_cycle"}, 32'(o_done(w)), 32'd0);
    end
  endtask

  initial begin
    int n;
    bit got;
    logic [2:0] iv;
    logic [31:0] av, bv, mask;
    logic [32:0] full;

    vt[0] = '{8'd200, 8'd55,  8'd145, 1'b0};
    vt[1] = '{8'd5,   8'd10,  8'd251, 1'b1};
    vt[2] = '{8'd0,   8'd1,   8'd255, 1'b1};
    vt[3] = '{8'd255, 8'd255, 8'd0,   1'b0};
    vt[4] = '{8'd100, 8'd1,   8'd99,  1'b0};
    vt[5] = '{8'd0,   8'd0,   8'd0,   1'b0};
    vt[6] = '{8'd128, 8'd1,   8'd127, 1'b0};
    vt[7] = '{8'd1,   8'd2,   8'd255, 1'b1};
    vt[8] = '{8'd37,  8'd200, 8'd93,  1'b1};

    // {d, bout} indexed by {x, y, bin}
    fs_exp[0] = 2'b00; fs_exp[1] = 2'b11; fs_exp[2] = 2'b11; fs_exp[3] = 2'b01;
    fs_exp[4] = 2'b10; fs_exp[5] = 2'b00; fs_exp[6] = 2'b00; fs_exp[7] = 2'b11;

    for (int i = 0; i < 8; i++) begin
      iv = 3'(i);
      {cx, cy, cb} = iv;
      #1;
      chk($sformatf("cell%0d_d", i), 32'(cd), 32'(fs_exp[i][1]));
      chk($sformatf("cell%0d_bout", i), 32'(cbo), 32'(fs_exp[i][0]));
    end

    // Reset state
    repeat (3) @(negedge clk);
    chk("rst busy8", 32'(busy8), 32'd0);
    chk("rst done8", 32'(done8), 32'd0);
    chk("rst diff8", 32'(diff8), 32'd0);
    chk("rst bo8", 32'(bo8), 32'd0);
    chk("rst busy16", 32'(busy16), 32'd0);
    chk("rst diff16", 32'(diff16), 32'd0);
    rst = 1'b0;

    for (int i = 0; i < 9; i++)
      run_op(8, 32'(vt[i].a), 32'(vt[i].b), 32'(vt[i].d), vt[i].bo, $sformatf("vec%0d", i));

    // Handshake: start held high, inputs changed mid-run, DONE relaunches
    @(negedge clk);
    drive(8, 1'b1, 100, 1);
    n = 0; got = 0;
    while (n < 12 && !got) begin
      @(negedge clk);
      n++;
      if (n == 1) drive(8, 1'b1, 7, 9);
      if (done8) got = 1;
    end
    chk("hs1 latency", 32'(n), 32'd9);
    chk("hs1 diff", 32'(diff8), 32'd99);
    chk("hs1 borrow", 32'(bo8), 32'd0);
    @(negedge clk);
    drive(8, 1'b0, 7, 9);
    chk("hs2 relaunch busy", 32'(busy8), 32'd1);
    chk("hs2 done dropped", 32'(done8), 32'd0);
    chk("hs2 diff held", 32'(diff8), 32'd99);
    n = 1; got = 0;
    while (n < 12 && !got) begin
      @(negedge clk);
      n++;
      if (n < 9) chk("hs2 diff stable", 32'(diff8), 32'd99);
      if (done8) got = 1;
    end
    chk("hs2 latency", 32'(n), 32'd9);
    chk("hs2 diff", 32'(diff8), 32'd254);
    chk("hs2 borrow", 32'(bo8), 32'd1);

    // Reset in the 4th RUN cycle aborts the op
    @(negedge clk);
    drive(8, 1'b1, 50, 20);
    @(negedge clk);
    drive(8, 1'b0, 50, 20);
    repeat (3) @(negedge clk);
    chk("midrst busy_before", 32'(busy8), 32'd1);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("midrst busy", 32'(busy8), 32'd0);
    chk("midrst done", 32'(done8), 32'd0);
    chk("midrst diff", 32'(diff8), 32'd0);
    chk("midrst borrow", 32'(bo8), 32'd0);
    got = 0;
    repeat (12) begin
      @(negedge clk);
      if (done8) got = 1;
    end
    chk("midrst no_done", 32'(got), 32'd0);
    run_op(8, 50, 20, 30, 1'b0, "after_rst");

    // Random, both widths
    for (int w = 8; w <= 16; w += 8) begin
      mask = (w == 8) ? 32'h0000_00ff : 32'h0000_ffff;
      for (int i = 0; i < 200; i++) begin
        av = $urandom & mask;
        bv = $urandom & mask;
        full = {1'b0, av} - {1'b0, bv};
        run_op(w, av, bv, full[31:0] & mask, full[w], $sformatf("rnd%0d_%0d", w, i));
      end
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
